svtime_rtc_counter: RTL and testbench

- Hardware wall-clock counter that keeps struct_time-style broken-down time plus an epoch-seconds count, advanced by a clock prescaler.
- Feeds the time_monitor stage directly upstream: publishes one coherent time record per elapsed second over a valid/ready handshake.
- Field encoding matches svtime struct_time (tm_year = years since 1900, tm_mon 0-11).

---
 rtl/svtime_rtc_counter.sv | 224 ++++++++++++++++++++++
 tb/tb_svtime_rtc_counter.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/svtime_rtc_counter.sv
// Wall-clock counter: struct_time fields plus epoch seconds, published once per second.
// Optional alarm compare is enabled by defining SVTIME_ALARM_EN.
module svtime_rtc_counter #(
  parameter int CLKS_PER_SEC = 1000,
  parameter int DROP_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              load,
  input  logic [5:0]        ld_sec,
  input  logic [5:0]        ld_min,
  input  logic [4:0]        ld_hour,
  input  logic [4:0]        ld_mday,
  input  logic [3:0]        ld_mon,
  input  logic [7:0]        ld_year,
  input  logic [2:0]        ld_wday,
  input  logic [8:0]        ld_yday,
  input  logic [63:0]       ld_epoch,
  output logic [5:0]        tm_sec,
  output logic [5:0]        tm_min,
  output logic [4:0]        tm_hour,
  output logic [4:0]        tm_mday,
  output logic [3:0]        tm_mon,
  output logic [7:0]        tm_year,
  output logic [2:0]        tm_wday,
  output logic [8:0]        tm_yday,
  output logic [63:0]       epoch,
  output logic              upd_valid,
  input  logic              upd_ready,
  output logic              sec_pulse,
`ifdef SVTIME_ALARM_EN
  input  logic              alarm_arm,
  input  logic [4:0]        alarm_hour,
  input  logic [5:0]        alarm_min,
  input  logic [5:0]        alarm_sec,
  output logic              alarm_hit,
`endif
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int PW = $clog2(CLKS_PER_SEC);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_SEC - 1);

  logic [PW-1:0]     r_presc;
  logic [5:0]        r_sec;
  logic [5:0]        r_min;
  logic [4:0]        r_hour;
  logic [4:0]        r_mday;
  logic [3:0]        r_mon;
  logic [7:0]        r_year;
  logic [2:0]        r_wday;
  logic [8:0]        r_yday;
  logic [63:0]       r_epoch;
  logic              r_upd_valid;
  logic              r_sec_pulse;
  logic [DROP_W-1:0] r_drop_cnt;

  logic              w_tick;
  logic              w_adv;
  logic              w_event;
  logic [4:0]        w_dim;
  logic [3:0]        w_wday_sum;
  logic [2:0]        w_wday_inc;
  logic [5:0]        w_adv_sec;
  logic [5:0]        w_adv_min;
  logic [4:0]        w_adv_hour;
  logic [4:0]        w_adv_mday;
  logic [3:0]        w_adv_mon;
  logic [7:0]        w_adv_year;
  logic [2:0]        w_adv_wday;
  logic [8:0]        w_adv_yday;

  function automatic logic [4:0] f_days_in_month(input logic [3:0] mon, input logic [7:0] year);
    logic [4:0] days;
    case (mon)
      4'd1:                    days = (year[1:0] == 2'b00) ? 5'd29 : 5'd28;
      4'd3, 4'd5, 4'd8, 4'd10: days = 5'd30;
      default:                 days = 5'd31;
    endcase
    return days;
  endfunction

  assign w_tick  = run && (r_presc == PRESC_LAST);
  assign w_adv   = w_tick && !load;
  assign w_event = load || w_tick;
  assign w_dim   = f_days_in_month(r_mon, r_year);

  // wday may hold a loaded 7; reducing wday+1 modulo 7 keeps it consistent.
  assign w_wday_sum = {1'b0, r_wday} + 4'd1;
  assign w_wday_inc = (w_wday_sum >= 4'd7) ? 3'(w_wday_sum - 4'd7) : w_wday_sum[2:0];

  always_comb begin
    w_adv_sec  = r_sec + 6'd1;
    w_adv_min  = r_min;
    w_adv_hour = r_hour;
    w_adv_mday = r_mday;
    w_adv_mon  = r_mon;
    w_adv_year = r_year;
    w_adv_wday = r_wday;
    w_adv_yday = r_yday;
    if (r_sec == 6'd59) begin
      w_adv_sec = 6'd0;
      w_adv_min = r_min + 6'd1;
      if (r_min == 6'd59) begin
        w_adv_min  = 6'd0;
        w_adv_hour = r_hour + 5'd1;
        if (r_hour == 5'd23) begin
          w_adv_hour = 5'd0;
          w_adv_wday = w_wday_inc;
          w_adv_yday = r_yday + 9'd1;
          w_adv_mday = r_mday + 5'd1;
          // >= rather than == so a loaded out-of-range mday self-corrects.
          if (r_mday >= w_dim) begin
            w_adv_mday = 5'd1;
            w_adv_mon  = r_mon + 4'd1;
            if (r_mon == 4'd11) begin
              w_adv_mon  = 4'd0;
              w_adv_yday = 9'd0;
              w_adv_year = (r_year == 8'd199) ? 8'd70 : r_year + 8'd1;
            end
          end
        end
      end
    end
  end

  // Handshake: a record is transferred on a cycle where upd_valid && upd_ready.
  // While upd_valid && !upd_ready the record is held, unless a newer event
  // overwrites it (counted in drop_cnt). An event coinciding with a transfer
  // publishes the new record without a drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc     <= '0;
      r_sec       <= 6'd0;
      r_min       <= 6'd0;
      r_hour      <= 5'd0;
      r_mday      <= 5'd1;
      r_mon       <= 4'd0;
      r_year      <= 8'd70;
      r_wday      <= 3'd4;
      r_yday      <= 9'd0;
      r_epoch     <= 64'd0;
      r_upd_valid <= 1'b0;
      r_sec_pulse <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      if (load) begin
        r_presc <= '0;
      end else if (run) begin
        r_presc <= w_tick ? '0 : r_presc + PW'(1);
      end

      if (load) begin
        r_sec   <= ld_sec;
        r_min   <= ld_min;
        r_hour  <= ld_hour;
        r_mday  <= ld_mday;
        r_mon   <= ld_mon;
        r_year  <= ld_year;
        r_wday  <= ld_wday;
        r_yday  <= ld_yday;
        r_epoch <= ld_epoch;
      end else if (w_adv) begin
        r_sec   <= w_adv_sec;
        r_min   <= w_adv_min;
        r_hour  <= w_adv_hour;
        r_mday  <= w_adv_mday;
        r_mon   <= w_adv_mon;
        r_year  <= w_adv_year;
        r_wday  <= w_adv_wday;
        r_yday  <= w_adv_yday;
        r_epoch <= r_epoch + 64'd1;
      end

      if (w_event) begin
        r_upd_valid <= 1'b1;
        r_sec_pulse <= w_adv;
        if (r_upd_valid && !upd_ready && (r_drop_cnt != '1)) begin
          r_drop_cnt <= r_drop_cnt + DROP_W'(1);
        end
      end else begin
        r_sec_pulse <= 1'b0;
        if (r_upd_valid && upd_ready) begin
          r_upd_valid <= 1'b0;
        end
      end
    end
  end

`ifdef SVTIME_ALARM_EN
  logic r_alarm_hit;
  logic w_alarm_match;

  assign w_alarm_match = (w_adv_hour == alarm_hour) && (w_adv_min == alarm_min) &&
                         (w_adv_sec == alarm_sec);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alarm_hit <= 1'b0;
    end else begin
      r_alarm_hit <= w_adv && alarm_arm && w_alarm_match;
    end
  end

  assign alarm_hit = r_alarm_hit;
`endif

  // Live time only changes on an event, and every event publishes it, so the
  // live registers double as the published record.
  assign tm_sec    = r_sec;
  assign tm_min    = r_min;
  assign tm_hour   = r_hour;
  assign tm_mday   = r_mday;
  assign tm_mon    = r_mon;
  assign tm_year   = r_year;
  assign tm_wday   = r_wday;
  assign tm_yday   = r_yday;
  assign epoch     = r_epoch;
  assign upd_valid = r_upd_valid;
  assign sec_pulse = r_sec_pulse;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_svtime_rtc_counter.sv
// Bench for svtime_rtc_counter: calendar model in seconds-of-day arithmetic plus
// a record queue; scenario tasks compare the DUT against it cycle by cycle.
module tb_svtime_rtc_counter;
  localparam int CPS   = 4;
  localparam int DW    = 4;
  localparam int REC_W = 110;
  localparam logic [REC_W-1:0] REC_1970 =
    {64'd0, 9'd0, 3'd4, 8'd70, 4'd0, 5'd1, 5'd0, 6'd0, 6'd0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, run, load, upd_ready;
  logic [5:0]  ld_sec, ld_min;
  logic [4:0]  ld_hour, ld_mday;
  logic [3:0]  ld_mon;
  logic [7:0]  ld_year;
  logic [2:0]  ld_wday;
  logic [8:0]  ld_yday;
  logic [63:0] ld_epoch;
  logic [5:0]  tm_sec, tm_min;
  logic [4:0]  tm_hour, tm_mday;
  logic [3:0]  tm_mon;
  logic [7:0]  tm_year;
  logic [2:0]  tm_wday;
  logic [8:0]  tm_yday;
  logic [63:0] epoch;
  logic        upd_valid, sec_pulse;
  logic [DW-1:0] drop_cnt;
`ifdef SVTIME_ALARM_EN
  logic        alarm_arm, alarm_hit;
  logic [4:0]  alarm_hour;
  logic [5:0]  alarm_min, alarm_sec;
`endif

  svtime_rtc_counter #(.CLKS_PER_SEC(CPS), .DROP_W(DW)) dut (
    .clk(clk), .rst(rst), .run(run), .load(load),
    .ld_sec(ld_sec), .ld_min(ld_min), .ld_hour(ld_hour), .ld_mday(ld_mday),
    .ld_mon(ld_mon), .ld_year(ld_year), .ld_wday(ld_wday), .ld_yday(ld_yday),
    .ld_epoch(ld_epoch),
    .tm_sec(tm_sec), .tm_min(tm_min), .tm_hour(tm_hour), .tm_mday(tm_mday),
    .tm_mon(tm_mon), .tm_year(tm_year), .tm_wday(tm_wday), .tm_yday(tm_yday),
    .epoch(epoch), .upd_valid(upd_valid), .upd_ready(upd_ready), .sec_pulse(sec_pulse),
`ifdef SVTIME_ALARM_EN
    .alarm_arm(alarm_arm), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
    .alarm_sec(alarm_sec), .alarm_hit(alarm_hit),
`endif
    .drop_cnt(drop_cnt)
  );

  logic [REC_W-1:0] dut_rec;
  assign dut_rec = {epoch, tm_yday, tm_wday, tm_year, tm_mon, tm_mday, tm_hour, tm_min, tm_sec};

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_sec, m_min, m_hour, m_mday, m_mon, m_year, m_wday, m_yday, m_presc;
  longint unsigned m_epoch;
  bit e_valid, e_pulse, e_hit;
  int e_drop;
  logic [REC_W-1:0] e_rec;
  logic [REC_W-1:0] exp_q[$];

  function automatic int days_in(input int mon, input int year);
    if (mon == 1) return (year % 4 == 0) ? 29 : 28;
    if (mon == 3 || mon == 5 || mon == 8 || mon == 10) return 30;
    return 31;
  endfunction

  function automatic logic [REC_W-1:0] pack_model();
    return {64'(m_epoch), 9'(m_yday), 3'(m_wday), 8'(m_year), 4'(m_mon), 5'(m_mday),
            5'(m_hour), 6'(m_min), 6'(m_sec)};
  endfunction

  task automatic model_reset();
    m_sec = 0; m_min = 0; m_hour = 0; m_mday = 1; m_mon = 0; m_year = 70;
    m_wday = 4; m_yday = 0; m_epoch = 0; m_presc = 0;
    e_valid = 0; e_pulse = 0; e_hit = 0; e_drop = 0;
    e_rec = pack_model();
    exp_q.delete();
  endtask

  task automatic model_advance();
    int sod;
    sod = m_hour * 3600 + m_min * 60 + m_sec + 1;
    if (sod == 86400) begin
      sod = 0;
      m_wday = (m_wday + 1) % 7;
      m_yday = (m_yday + 1) % 512;
      if (m_mday >= days_in(m_mon, m_year)) begin
        m_mday = 1;
        if (m_mon == 11) begin
          m_mon = 0;
          m_yday = 0;
          m_year = (m_year == 199) ? 70 : m_year + 1;
        end else begin
          m_mon = m_mon + 1;
        end
      end else begin
        m_mday = m_mday + 1;
      end
    end
    m_hour = sod / 3600;
    m_min  = (sod / 60) % 60;
    m_sec  = sod % 60;
    m_epoch = m_epoch + 1;
  endtask

  // One clock: update the model from the inputs now applied, then sample at +1.
  task automatic step();
    bit tick, ev;
    if (rst) begin
      model_reset();
    end else begin
      tick = run && (m_presc == CPS - 1);
      ev = load || tick;
      if (load) begin
        m_sec = int'(ld_sec); m_min = int'(ld_min); m_hour = int'(ld_hour);
        m_mday = int'(ld_mday); m_mon = int'(ld_mon); m_year = int'(ld_year);
        m_wday = int'(ld_wday); m_yday = int'(ld_yday); m_epoch = ld_epoch;
        m_presc = 0;
      end else if (run) begin
        if (tick) begin
          m_presc = 0;
          model_advance();
        end else begin
          m_presc = m_presc + 1;
        end
      end
      if (ev) begin
        if (e_valid && !upd_ready && e_drop < (1 << DW) - 1) e_drop++;
        e_valid = 1;
        e_pulse = tick && !load;
        e_rec = pack_model();
        exp_q.push_back(e_rec);
`ifdef SVTIME_ALARM_EN
        e_hit = tick && !load && alarm_arm && m_hour == int'(alarm_hour) &&
                m_min == int'(alarm_min) && m_sec == int'(alarm_sec);
`endif
      end else begin
        if (e_valid && upd_ready) e_valid = 0;
        e_pulse = 0;
        e_hit = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_ld(input int y, input int mo, input int md, input int yd, input int wd,
                        input int h, input int mi, input int s, input logic [63:0] ep);
    ld_year = 8'(y); ld_mon = 4'(mo); ld_mday = 5'(md); ld_yday = 9'(yd); ld_wday = 3'(wd);
    ld_hour = 5'(h); ld_min = 6'(mi); ld_sec = 6'(s); ld_epoch = ep;
  endtask

  task automatic do_reset();
    rst = 1; load = 0;
    step();
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    run = 1; upd_ready = 0;
    do_reset();
    total++; if (upd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", upd_valid); end
    total++; if (sec_pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse got=%0b want=0", sec_pulse); end
    total++; if (drop_cnt !== '0) begin bad++; $display("FAIL reset_drop got=%0d want=0", drop_cnt); end
    total++; if (dut_rec !== REC_1970) begin bad++; $display("FAIL reset_rec got=%h want=%h", dut_rec, REC_1970); end
  endtask

  task automatic test_basic();
    int n_rec, n_pulse, first_sec;
    logic [63:0] first_ep;
    logic [REC_W-1:0] want;
    n_rec = 0; n_pulse = 0; first_sec = -1; first_ep = '1;
    run = 1; upd_ready = 1;
    for (int i = 0; i < 2 * CPS; i++) begin
      step();
      total++; if (sec_pulse !== e_pulse) begin bad++; $display("FAIL basic_pulse cyc=%0d got=%0b want=%0b", i, sec_pulse, e_pulse); end
      if (sec_pulse) n_pulse++;
      if (upd_valid) begin
        n_rec++;
        if (first_sec < 0) begin first_sec = int'(tm_sec); first_ep = epoch; end
        want = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        total++; if (dut_rec !== want) begin bad++; $display("FAIL basic_rec got=%h want=%h", dut_rec, want); end
      end
    end
    total++; if (n_rec != 2) begin bad++; $display("FAIL basic_nrec got=%0d want=2", n_rec); end
    total++; if (n_pulse != 2) begin bad++; $display("FAIL basic_npulse got=%0d want=2", n_pulse); end
    total++; if (first_sec != 1 || first_ep != 64'd1) begin bad++; $display("FAIL basic_first got=%0d/%0d want=1/1", first_sec, first_ep); end
    total++; if (tm_sec !== 6'd2 || epoch !== 64'd2) begin bad++; $display("FAIL basic_second got=%0d/%0d want=2/2", tm_sec, epoch); end
  endtask

  task automatic test_leap();
    run = 1; upd_ready = 1;
    set_ld(116, 1, 28, 58, 0, 23, 59, 59, 64'd1456703999);
    load = 1; step(); load = 0;
    total++; if (dut_rec !== e_rec || sec_pulse !== 1'b0 || upd_valid !== 1'b1)
      begin bad++; $display("FAIL leap_load got=%h/%0b/%0b want=%h/0/1", dut_rec, sec_pulse, upd_valid, e_rec); end
    for (int i = 0; i < 2 * CPS && !sec_pulse; i++) step();
    total++; if (!sec_pulse) begin bad++; $display("FAIL leap_timeout got=0 want=pulse"); end
    total++; if (tm_mday !== 5'd29 || tm_mon !== 4'd1 || tm_wday !== 3'd1 || tm_yday !== 9'd59 || tm_hour !== 5'd0)
      begin bad++; $display("FAIL leap_fields got=%0d/%0d/%0d/%0d want=29/1/1/59", tm_mday, tm_mon, tm_wday, tm_yday); end
    total++; if (epoch !== 64'd1456704000) begin bad++; $display("FAIL leap_epoch got=%0d want=1456704000", epoch); end
    total++; if (dut_rec !== e_rec) begin bad++; $display("FAIL leap_rec got=%h want=%h", dut_rec, e_rec); end
    set_ld(115, 1, 28, 58, 6, 23, 59, 59, 64'd1425167999);
    load = 1; step(); load = 0;
    for (int i = 0; i < 2 * CPS && !sec_pulse; i++) step();
    total++; if (!sec_pulse) begin bad++; $display("FAIL noleap_timeout got=0 want=pulse"); end
    total++; if (tm_mday !== 5'd1 || tm_mon !== 4'd2 || tm_yday !== 9'd59 || epoch !== 64'd1425168000)
      begin bad++; $display("FAIL noleap_fields got=%0d/%0d/%0d/%0d want=1/2/59/1425168000", tm_mday, tm_mon, tm_yday, epoch); end
    total++; if (dut_rec !== e_rec) begin bad++; $display("FAIL noleap_rec got=%h want=%h", dut_rec, e_rec); end
  endtask

  task automatic test_year_wrap();
    run = 1; upd_ready = 1;
    set_ld(199, 11, 31, 364, 4, 23, 59, 59, 64'd4102444799);
    load = 1; step(); load = 0;
    for (int i = 0; i < 2 * CPS && !sec_pulse; i++) step();
    total++; if (!sec_pulse) begin bad++; $display("FAIL wrap_timeout got=0 want=pulse"); end
    total++; if (tm_year !== 8'd70 || tm_mon !== 4'd0 || tm_mday !== 5'd1 || tm_yday !== 9'd0)
      begin bad++; $display("FAIL wrap_date got=%0d/%0d/%0d/%0d want=70/0/1/0", tm_year, tm_mon, tm_mday, tm_yday); end
    total++; if (tm_hour !== 5'd0 || tm_min !== 6'd0 || tm_sec !== 6'd0 || tm_wday !== 3'd5)
      begin bad++; $display("FAIL wrap_time got=%0d:%0d:%0d w%0d want=0:0:0 w5", tm_hour, tm_min, tm_sec, tm_wday); end
    total++; if (epoch !== 64'd4102444800) begin bad++; $display("FAIL wrap_epoch got=%0d want=4102444800", epoch); end
  endtask

  task automatic test_stall();
    int pulses;
    run = 1; upd_ready = 0;
    do_reset();
    pulses = 0;
    for (int i = 0; i < 4 * CPS && pulses < 3; i++) begin
      step();
      if (sec_pulse) begin
        pulses++;
        total++; if (drop_cnt !== DW'(pulses - 1)) begin bad++; $display("FAIL stall_drop got=%0d want=%0d", drop_cnt, pulses - 1); end
        total++; if (tm_sec !== 6'(pulses)) begin bad++; $display("FAIL stall_sec got=%0d want=%0d", tm_sec, pulses); end
      end
      if (pulses > 0) begin
        total++; if (upd_valid !== 1'b1 || dut_rec !== e_rec)
          begin bad++; $display("FAIL stall_hold got=%0b/%h want=1/%h", upd_valid, dut_rec, e_rec); end
      end
    end
    total++; if (pulses != 3) begin bad++; $display("FAIL stall_npulse got=%0d want=3", pulses); end
    run = 0; upd_ready = 1;
    step();
    total++; if (upd_valid !== 1'b0 || drop_cnt !== DW'(2))
      begin bad++; $display("FAIL stall_release got=%0b/%0d want=0/2", upd_valid, drop_cnt); end
  endtask

  task automatic test_load_at_tick();
    int cnt, n_valid, n_pulse;
    run = 1; upd_ready = 1;
    do_reset();
    for (int i = 0; i < 2 * CPS && m_presc != CPS - 1; i++) step();
    set_ld(100, 5, 15, 165, 3, 12, 30, 45, 64'd123456789);
    load = 1; step(); load = 0;
    total++; if (sec_pulse !== 1'b0 || upd_valid !== 1'b1 || tm_sec !== 6'd45)
      begin bad++; $display("FAIL ldtick_pub got=%0b/%0b/%0d want=0/1/45", sec_pulse, upd_valid, tm_sec); end
    total++; if (dut_rec !== e_rec) begin bad++; $display("FAIL ldtick_rec got=%h want=%h", dut_rec, e_rec); end
    cnt = 0;
    for (int i = 1; i <= 2 * CPS; i++) begin
      step();
      if (sec_pulse) begin cnt = i; break; end
    end
    total++; if (cnt != CPS || tm_sec !== 6'd46)
      begin bad++; $display("FAIL ldtick_presc got=%0d/%0d want=%0d/46", cnt, tm_sec, CPS); end
    run = 0; n_valid = 0; n_pulse = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (upd_valid) n_valid++;
      if (sec_pulse) n_pulse++;
    end
    total++; if (n_valid != 0 || n_pulse != 0)
      begin bad++; $display("FAIL frozen got=%0d/%0d want=0/0", n_valid, n_pulse); end
  endtask

  task automatic test_drop_sat();
    run = 0; upd_ready = 0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_ld(120, 6, 10, 190, 2, 8, i, 0, 64'(i));
      load = 1; step();
    end
    load = 0;
    total++; if (drop_cnt !== DW'((1 << DW) - 1) || upd_valid !== 1'b1)
      begin bad++; $display("FAIL drop_sat got=%0d/%0b want=%0d/1", drop_cnt, upd_valid, (1 << DW) - 1); end
    total++; if (tm_min !== 6'd19 || epoch !== 64'd19)
      begin bad++; $display("FAIL drop_newest got=%0d/%0d want=19/19", tm_min, epoch); end
  endtask

  task automatic test_reset_mid();
    run = 1; upd_ready = 0;
    step();
    rst = 1; step(); rst = 0;
    total++; if (upd_valid !== 1'b0 || drop_cnt !== '0 || sec_pulse !== 1'b0)
      begin bad++; $display("FAIL rstmid_ctl got=%0b/%0d/%0b want=0/0/0", upd_valid, drop_cnt, sec_pulse); end
    total++; if (dut_rec !== REC_1970) begin bad++; $display("FAIL rstmid_rec got=%h want=%h", dut_rec, REC_1970); end
  endtask

  task automatic test_random();
    int y, mo;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      run = ($urandom_range(0, 9) != 0);
      upd_ready = ($urandom_range(0, 3) != 0);
      load = ($urandom_range(0, 29) == 0);
`ifdef SVTIME_ALARM_EN
      alarm_arm = 1'b1;
      alarm_hour = 5'd0; alarm_min = 6'd0; alarm_sec = 6'($urandom_range(0, 2));
`endif
      if (load) begin
        y = int'($urandom_range(70, 199));
        mo = ($urandom_range(0, 1) != 0) ? 11 : int'($urandom_range(0, 11));
        set_ld(y, mo, int'($urandom_range(1, days_in(mo, y))), int'($urandom_range(0, 365)),
               int'($urandom_range(0, 6)),
               ($urandom_range(0, 1) != 0) ? 23 : int'($urandom_range(0, 23)),
               ($urandom_range(0, 1) != 0) ? 59 : int'($urandom_range(0, 59)),
               int'($urandom_range(55, 59)), {32'd0, $urandom});
      end
      step();
      total++; if (upd_valid !== e_valid || sec_pulse !== e_pulse)
        begin bad++; $display("FAIL rand_ctl cyc=%0d got=%0b/%0b want=%0b/%0b", i, upd_valid, sec_pulse, e_valid, e_pulse); end
      total++; if (drop_cnt !== DW'(e_drop)) begin bad++; $display("FAIL rand_drop cyc=%0d got=%0d want=%0d", i, drop_cnt, e_drop); end
      total++; if (dut_rec !== e_rec) begin bad++; $display("FAIL rand_rec cyc=%0d got=%h want=%h", i, dut_rec, e_rec); end
`ifdef SVTIME_ALARM_EN
      total++; if (alarm_hit !== e_hit) begin bad++; $display("FAIL rand_alarm cyc=%0d got=%0b want=%0b", i, alarm_hit, e_hit); end
`endif
    end
    load = 0;
  endtask

`ifdef SVTIME_ALARM_EN
  task automatic test_alarm();
    int hits;
    alarm_arm = 1; alarm_hour = 5'd0; alarm_min = 6'd0; alarm_sec = 6'd3;
    run = 1; upd_ready = 1;
    do_reset();
    hits = 0;
    for (int i = 0; i < 6 * CPS; i++) begin
      step();
      total++; if (alarm_hit !== e_hit) begin bad++; $display("FAIL alarm_cyc cyc=%0d got=%0b want=%0b", i, alarm_hit, e_hit); end
      if (alarm_hit) begin
        hits++;
        total++; if (tm_sec !== 6'd3 || upd_valid !== 1'b1)
          begin bad++; $display("FAIL alarm_rec got=%0d/%0b want=3/1", tm_sec, upd_valid); end
      end
    end
    total++; if (hits != 1) begin bad++; $display("FAIL alarm_count got=%0d want=1", hits); end
  endtask
`endif

  initial begin
    rst = 1; run = 0; load = 0; upd_ready = 0;
    set_ld(70, 0, 1, 0, 4, 0, 0, 0, 64'd0);
`ifdef SVTIME_ALARM_EN
    alarm_arm = 0; alarm_hour = 5'd0; alarm_min = 6'd0; alarm_sec = 6'd0;
`endif
    model_reset();
    test_reset();
    test_basic();
    test_leap();
    test_year_wrap();
    test_stall();
    test_load_at_tick();
    test_drop_sat();
    test_reset_mid();
`ifdef SVTIME_ALARM_EN
    test_alarm();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
